false_lock_detector: RTL



---
 rtl/false_lock_pkg.sv | 21 ++
 rtl/fl_leaky_integrator.sv | 71 +++++++
 rtl/false_lock_detector.sv | 125 ++++++++++++
 3 files changed

// File: rtl/false_lock_pkg.sv
// Shared types, widths and helpers for the false-lock detector.
// The hysteresis low level is shared between the RTL and any consumer of the threshold register.
package false_lock_pkg;

    localparam int ACC_W = 32;
    localparam int MAG_W = 16;

    typedef enum logic [2:0] {
        FL_UNLOCKED = 3'd0,
        FL_CLEAR    = 3'd1,
        FL_PEND_SET = 3'd2,
        FL_FLAGGED  = 3'd3,
        FL_PEND_CLR = 3'd4
    } flState_t;

    // Low level of the hysteresis band: threshold minus one eighth of itself.
    function automatic logic [MAG_W-1:0] thrLo(input logic [MAG_W-1:0] thr);
        return thr - (thr >> 3);
    endfunction

endpackage

// File: rtl/fl_leaky_integrator.sv
// Stages 1-2: saturated magnitude of the frequency error, then a first-order
// leaky average acc += ((mag<<16 - acc) * alpha) >>> 16, clamped to 32 bits.
module fl_leaky_integrator
    import false_lock_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clkEn,
    input  logic signed [MAG_W-1:0] freqErr,
    input  logic        [MAG_W-1:0] alpha,
    output logic        [MAG_W-1:0] avgMag,
    output logic                    avgValid
);

    localparam int PROD_W = ACC_W + MAG_W + 2;

    logic [MAG_W-1:0]         magNext;
    logic [MAG_W-1:0]         mag;
    logic                     en1;
    logic [ACC_W-1:0]         acc;
    logic [ACC_W-1:0]         accNext;
    logic signed [ACC_W:0]    diff;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] sum;

    // -32768 has no positive counterpart, so it saturates to 0x7FFF.
    always_comb begin
        if (freqErr == {1'b1, {(MAG_W-1){1'b0}}}) begin
            magNext = {1'b0, {(MAG_W-1){1'b1}}};
        end else if (freqErr[MAG_W-1]) begin
            magNext = -freqErr;
        end else begin
            magNext = freqErr;
        end
    end

    // NOTE: every combinational output gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        diff    = $signed({1'b0, mag, {MAG_W{1'b0}}}) - $signed({1'b0, acc});
        prod    = diff * $signed({1'b0, alpha});
        sum     = $signed({{(MAG_W+2){1'b0}}, acc}) + (prod >>> MAG_W);
        accNext = sum[ACC_W-1:0];
        if (sum[PROD_W-1]) begin
            accNext = '0;
        end else if (|sum[PROD_W-2:ACC_W]) begin
            accNext = '1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mag      <= '0;
            en1      <= 1'b0;
            acc      <= '0;
            avgValid <= 1'b0;
        end else begin
            en1      <= clkEn;
            avgValid <= en1;
            if (clkEn) begin
                mag <= magNext;
            end
            if (en1) begin
                acc <= accNext;
            end
        end
    end

    assign avgMag = acc[ACC_W-1 -: MAG_W];

endmodule

// File: rtl/false_lock_detector.sv
// False-lock detector: leaky-averaged error magnitude compared against a
// hysteresis band, qualified by a dwell counter and gated by demod lock.
module false_lock_detector
    import false_lock_pkg::*;
#(
    parameter int unsigned DWELL_COUNT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clkEn,
    input  logic signed [MAG_W-1:0] freqErr,
    input  logic                    demodLock,
    input  logic        [MAG_W-1:0] falseLockAlpha,
    input  logic        [MAG_W-1:0] falseLockThreshold,
    output logic                    highFreqOffset,
    output logic        [MAG_W-1:0] avgMag
);

    localparam logic [CNT_W-1:0] DWELL_LIM = CNT_W'(DWELL_COUNT);
    localparam bit               SINGLE    = (DWELL_COUNT == 1);

    flState_t         state;
    flState_t         stateNext;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;
    logic [CNT_W-1:0] cntInc;
    logic             dwellDone;
    logic             en2;
    logic [MAG_W-1:0] thrLoVal;
    logic             isHigh;
    logic             isLow;
    logic             flagNext;

    fl_leaky_integrator uIntegrator (
        .clk      (clk),
        .reset_n  (reset_n),
        .clkEn    (clkEn),
        .freqErr  (freqErr),
        .alpha    (falseLockAlpha),
        .avgMag   (avgMag),
        .avgValid (en2)
    );

    // Values inside [thrLo, threshold] are neither High nor Low.
    assign thrLoVal  = thrLo(falseLockThreshold);
    assign isHigh    = (avgMag > falseLockThreshold);
    assign isLow     = (avgMag < thrLoVal);
    assign cntInc    = cnt + 1'b1;
    assign dwellDone = (cntInc >= DWELL_LIM);

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        if (!demodLock) begin
            stateNext = FL_UNLOCKED;
            cntNext   = '0;
        end else begin
            unique case (state)
                FL_UNLOCKED: begin
                    stateNext = FL_CLEAR;
                    cntNext   = '0;
                end
                FL_CLEAR: begin
                    if (en2 && isHigh) begin
                        stateNext = SINGLE ? FL_FLAGGED : FL_PEND_SET;
                        cntNext   = SINGLE ? '0 : CNT_W'(1);
                    end
                end
                FL_PEND_SET: begin
                    if (en2) begin
                        if (!isHigh) begin
                            stateNext = FL_CLEAR;
                            cntNext   = '0;
                        end else if (dwellDone) begin
                            stateNext = FL_FLAGGED;
                            cntNext   = '0;
                        end else begin
                            cntNext = cntInc;
                        end
                    end
                end
                FL_FLAGGED: begin
                    if (en2 && isLow) begin
                        stateNext = SINGLE ? FL_CLEAR : FL_PEND_CLR;
                        cntNext   = SINGLE ? '0 : CNT_W'(1);
                    end
                end
                FL_PEND_CLR: begin
                    if (en2) begin
                        if (!isLow) begin
                            stateNext = FL_FLAGGED;
                            cntNext   = '0;
                        end else if (dwellDone) begin
                            stateNext = FL_CLEAR;
                            cntNext   = '0;
                        end else begin
                            cntNext = cntInc;
                        end
                    end
                end
                default: begin
                    stateNext = FL_UNLOCKED;
                    cntNext   = '0;
                end
            endcase
        end
    end

    // The flag stays up while a clear is pending.
    assign flagNext = (stateNext == FL_FLAGGED) || (stateNext == FL_PEND_CLR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= FL_UNLOCKED;
            cnt            <= '0;
            highFreqOffset <= 1'b0;
        end else begin
            state          <= stateNext;
            cnt            <= cntNext;
            highFreqOffset <= flagNext;
        end
    end

endmodule
